// File: rtl/bottomhalf_bus_core.sv
`default_nettype none
// ============================================================================
// Module   : bottomhalf_bus_core
// Purpose  : Fully synchronous host-bus front end for bottom-half bitfiles.
//            Oversamples the host ALE/WRITE/READ strobes, latches the command
//            address, produces single-cycle write/read strobes for the
//            payload, serves ID/status bytes on readback and provides a
//            programmable microsecond delay timer.
// Ports    : osc        - system clock (only clock)
//            rst        - synchronous reset, active high
//            bus_ale    - host address-latch strobe (raw pin)
//            bus_write  - host write strobe, rising edge commits a write
//            bus_read   - host read strobe, active low
//            bus_din    - host data bus, input side
//            bus_dout   - data driven to host when bus_oe=1
//            bus_oe     - data bus output enable (combinational on bus_read)
//            wr_stb     - one-cycle write pulse, with wr_addr / wr_data
//            rd_stb     - one-cycle read-request pulse, with rd_addr
//            rd_data    - payload read data, sampled while rd_stb is high
//            dly_start  - load delay timer (ignored while dly_busy=1)
//            dly_usec   - delay length in microseconds
//            dly_busy   - high while the delay timer runs
// Revision : 1.0 - initial release
// ============================================================================
module bottomhalf_bus_core #(
    parameter logic [15:0] TYPE        = 16'h0000,
    parameter logic [7:0]  SUBTYPE     = 8'h00,
    parameter int          CLK_MHZ     = 24,
    parameter int          DELAY_W     = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int          ADDR_OK_BIT = 4
) (
    input  logic        osc,
    input  logic        rst,
    input  logic        bus_ale,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    output logic        bus_oe,
    output logic        wr_stb,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_stb,
    output logic [7:0]  rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        dly_start,
    input  logic [11:0] dly_usec,
    output logic        dly_busy
);

    // Product is formed 8 bits wider than the counter so overflow is visible.
    localparam int PROD_W = DELAY_W + 8;

    // Synchroniser chains: bit 0 is the newest sample, bit SYNC_STAGES-1 the
    // settled one used for edge detection.
    logic [SYNC_STAGES-1:0] r_ale_sync;
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [7:0]             r_din_sync [SYNC_STAGES];

    logic                   r_ale_hist;
    logic                   r_wr_hist;
    logic                   r_rd_hist;

    logic [7:0]             r_addr;
    logic                   r_wr_stb;
    logic [7:0]             r_wr_addr;
    logic [7:0]             r_wr_data;
    logic                   r_rd_stb;
    logic [7:0]             r_rd_addr;
    logic [7:0]             r_bus_dout;
    logic [DELAY_W-1:0]     r_count;

    logic                   w_ale_s;
    logic                   w_wr_s;
    logic                   w_rd_s;
    logic [7:0]             w_din_s;
    logic                   w_ale_fall;
    logic                   w_wr_rise;
    logic                   w_rd_fall;
    logic                   w_busy;
    logic [7:0]             w_rd_mux;
    logic [PROD_W-1:0]      w_prod;
    logic [DELAY_W-1:0]     w_load;

    assign w_ale_s = r_ale_sync[SYNC_STAGES-1];
    assign w_wr_s  = r_wr_sync[SYNC_STAGES-1];
    assign w_rd_s  = r_rd_sync[SYNC_STAGES-1];
    assign w_din_s = r_din_sync[SYNC_STAGES-1];

    assign w_ale_fall = r_ale_hist & ~w_ale_s;
    assign w_wr_rise  = ~r_wr_hist & w_wr_s;
    assign w_rd_fall  = r_rd_hist & ~w_rd_s;

    // ------------------------------------------------------------------------
    // Synchronisers and edge history. The read chain and its history reset to
    // the idle (high) level so releasing reset never looks like a READ edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge osc) begin
        if (rst) begin
            r_ale_sync <= '0;
            r_wr_sync  <= '0;
            r_rd_sync  <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_din_sync[i] <= '0;
            end
            r_ale_hist <= 1'b0;
            r_wr_hist  <= 1'b0;
            r_rd_hist  <= 1'b1;
        end else begin
            r_ale_sync    <= {r_ale_sync[SYNC_STAGES-2:0], bus_ale};
            r_wr_sync     <= {r_wr_sync[SYNC_STAGES-2:0], bus_write};
            r_rd_sync     <= {r_rd_sync[SYNC_STAGES-2:0], bus_read};
            r_din_sync[0] <= bus_din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_din_sync[i] <= r_din_sync[i-1];
            end
            r_ale_hist <= w_ale_s;
            r_wr_hist  <= w_wr_s;
            r_rd_hist  <= w_rd_s;
        end
    end

    // ------------------------------------------------------------------------
    // Address latch and strobes. Strobes sample r_addr in the same edge the
    // latch may be reloaded, so a coincident ALE edge uses the old address.
    // ------------------------------------------------------------------------
    always_ff @(posedge osc) begin
        if (rst) begin
            r_addr    <= '0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_stb  <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_wr_stb <= w_wr_rise;
            r_rd_stb <= w_rd_fall;
            if (w_ale_fall) begin
                r_addr <= w_din_s;
            end
            if (w_wr_rise) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_din_s;
            end
            if (w_rd_fall) begin
                r_rd_addr <= r_addr;
            end
        end
    end

    // Readback source selected by the address captured with rd_stb.
    always_comb begin
        w_rd_mux = rd_data;
        case (r_rd_addr)
            8'hFC:   w_rd_mux = {7'b0, w_busy};
            8'hFD:   w_rd_mux = TYPE[7:0];
            8'hFE:   w_rd_mux = TYPE[15:8];
            8'hFF:   w_rd_mux = SUBTYPE;
            default: w_rd_mux = rd_data;
        endcase
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            r_bus_dout <= '0;
        end else if (r_rd_stb) begin
            r_bus_dout <= w_rd_mux;
        end
    end

    // ------------------------------------------------------------------------
    // Delay timer: load CLK_MHZ*usec (saturated), count down to zero.
    // ------------------------------------------------------------------------
    assign w_prod = PROD_W'(CLK_MHZ) * PROD_W'(dly_usec);
    assign w_load = (w_prod[PROD_W-1:DELAY_W] != '0) ? '1 : w_prod[DELAY_W-1:0];
    assign w_busy = (r_count != '0);

    always_ff @(posedge osc) begin
        if (rst) begin
            r_count <= '0;
        end else if (dly_start && !w_busy) begin
            r_count <= w_load;
        end else if (w_busy) begin
            r_count <= r_count - DELAY_W'(1);
        end
    end

    assign bus_dout = r_bus_dout;
    // Raw pin, not the synchronised copy, so the bus is released immediately.
    assign bus_oe   = ~bus_read & r_addr[ADDR_OK_BIT];
    assign wr_stb   = r_wr_stb;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign rd_stb   = r_rd_stb;
    assign rd_addr  = r_rd_addr;
    assign dly_busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_bottomhalf_bus_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_bottomhalf_bus_core
// Purpose  : Self-checking bench for bottomhalf_bus_core. A main instance with
//            TYPE=16'hBEEF / SUBTYPE=8'h07 / DELAY_W=16 and a second instance
//            with DELAY_W=8 for counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bottomhalf_bus_core;

    logic        osc = 1'b0;
    logic        rst;
    logic        bus_ale;
    logic        bus_write;
    logic        bus_read;
    logic [7:0]  bus_din;
    logic [7:0]  rd_data;
    logic        dly_start;
    logic [11:0] dly_usec;
    logic        dly_start8;
    logic [11:0] dly_usec8;

    logic [7:0]  bus_dout,  bus_dout8;
    logic        bus_oe,    bus_oe8;
    logic        wr_stb,    wr_stb8;
    logic [7:0]  wr_addr,   wr_addr8;
    logic [7:0]  wr_data,   wr_data8;
    logic        rd_stb,    rd_stb8;
    logic [7:0]  rd_addr,   rd_addr8;
    logic        dly_busy,  dly_busy8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 osc = ~osc;

    bottomhalf_bus_core #(
        .TYPE(16'hBEEF), .SUBTYPE(8'h07), .CLK_MHZ(24),
        .DELAY_W(16), .SYNC_STAGES(2), .ADDR_OK_BIT(4)
    ) dut (
        .osc(osc), .rst(rst), .bus_ale(bus_ale), .bus_write(bus_write),
        .bus_read(bus_read), .bus_din(bus_din), .bus_dout(bus_dout),
        .bus_oe(bus_oe), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_stb(rd_stb), .rd_addr(rd_addr), .rd_data(rd_data),
        .dly_start(dly_start), .dly_usec(dly_usec), .dly_busy(dly_busy)
    );

    bottomhalf_bus_core #(
        .TYPE(16'h0000), .SUBTYPE(8'h00), .CLK_MHZ(24),
        .DELAY_W(8), .SYNC_STAGES(2), .ADDR_OK_BIT(4)
    ) dut8 (
        .osc(osc), .rst(rst), .bus_ale(bus_ale), .bus_write(bus_write),
        .bus_read(bus_read), .bus_din(bus_din), .bus_dout(bus_dout8),
        .bus_oe(bus_oe8), .wr_stb(wr_stb8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .rd_stb(rd_stb8), .rd_addr(rd_addr8), .rd_data(rd_data),
        .dly_start(dly_start8), .dly_usec(dly_usec8), .dly_busy(dly_busy8)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] payload;
        logic [7:0] exp_dout;
        logic       exp_oe;
    } rd_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge osc);
    endtask

    task automatic set_addr(input logic [7:0] a);
        @(negedge osc);
        bus_ale = 1'b1;
        bus_din = a;
        cycles(4);
        bus_ale = 1'b0;
        cycles(4);
    endtask

    // Raise WRITE (optionally together with an ALE fall) and watch the strobe.
    task automatic do_write(input logic [7:0] d, input logic with_ale_fall,
                            input logic [7:0] exp_addr, input string name);
        int pulses;
        int at;
        logic [7:0] got_addr;
        logic [7:0] got_data;
        pulses = 0; at = -1; got_addr = '0; got_data = '0;
        @(negedge osc);
        bus_din   = d;
        bus_write = 1'b1;
        if (with_ale_fall) bus_ale = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge osc);
            if (wr_stb) begin
                pulses++;
                at = i;
                got_addr = wr_addr;
                got_data = wr_data;
            end
        end
        bus_write = 1'b0;
        cycles(4);
        chk({name, " wr_stb count"}, pulses, 1);
        chk({name, " wr_stb latency"}, at, 3);
        chk({name, " wr_addr"}, got_addr, exp_addr);
        chk({name, " wr_data"}, got_data, d);
    endtask

    task automatic do_read(input rd_vec_t v, input string name);
        int pulses;
        logic [7:0] got_addr;
        pulses = 0; got_addr = '0;
        rd_data = v.payload;
        @(negedge osc);
        bus_read = 1'b0;
        #1;
        chk({name, " oe while low"}, bus_oe, v.exp_oe);
        for (int i = 1; i <= 7; i++) begin
            @(negedge osc);
            if (rd_stb) begin
                pulses++;
                got_addr = rd_addr;
            end
        end
        chk({name, " rd_stb count"}, pulses, 1);
        chk({name, " rd_addr"}, got_addr, v.addr);
        chk({name, " bus_dout"}, bus_dout, v.exp_dout);
        bus_read = 1'b1;
        #1;
        chk({name, " oe released"}, bus_oe, 1'b0);
        cycles(4);
    endtask

    rd_vec_t vecs [6];

    initial begin
        int busy_cnt;
        int first_busy;
        int last_busy;
        int stb_cnt;

        vecs[0] = '{addr: 8'hFD, payload: 8'h00, exp_dout: 8'hEF, exp_oe: 1'b1};
        vecs[1] = '{addr: 8'hFE, payload: 8'h11, exp_dout: 8'hBE, exp_oe: 1'b1};
        vecs[2] = '{addr: 8'hFF, payload: 8'h33, exp_dout: 8'h07, exp_oe: 1'b1};
        vecs[3] = '{addr: 8'h05, payload: 8'h5A, exp_dout: 8'h5A, exp_oe: 1'b0};
        vecs[4] = '{addr: 8'h17, payload: 8'h3C, exp_dout: 8'h3C, exp_oe: 1'b1};
        vecs[5] = '{addr: 8'hFC, payload: 8'h99, exp_dout: 8'h00, exp_oe: 1'b1};

        rst = 1'b1; bus_ale = 1'b0; bus_write = 1'b0; bus_read = 1'b1;
        bus_din = '0; rd_data = '0; dly_start = 1'b0; dly_usec = '0;
        dly_start8 = 1'b0; dly_usec8 = '0;
        cycles(3);
        chk("reset outputs", {bus_dout, bus_oe, wr_stb, wr_addr, wr_data, rd_stb, rd_addr, dly_busy},
            '0);
        rst = 1'b0;
        cycles(4);
        chk("no strobe after reset", {wr_stb, rd_stb}, 2'b00);

        // Basic write.
        set_addr(8'h12);
        do_write(8'hA5, 1'b0, 8'h12, "write12");

        // Readback table.
        for (int k = 0; k < 6; k++) begin
            set_addr(vecs[k].addr);
            do_read(vecs[k], $sformatf("read%02h", vecs[k].addr));
        end

        // ALE fall coincident with WRITE rise: strobe carries the old address.
        set_addr(8'h33);
        @(negedge osc);
        bus_ale = 1'b1;
        bus_din = 8'h55;
        cycles(4);
        do_write(8'h55, 1'b1, 8'h33, "ale+write");
        do_write(8'h66, 1'b0, 8'h55, "after ale+write");

        // Delay: 3 us at 24 MHz = 72 cycles; restart attempt and FC read mid-delay.
        set_addr(8'hFC);
        busy_cnt = 0; first_busy = -1; last_busy = -1; stb_cnt = 0;
        @(negedge osc);
        dly_usec  = 12'd3;
        dly_start = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge osc);
            if (dly_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = i;
                last_busy = i;
            end
            if (rd_stb) stb_cnt++;
            if (i == 1 || i == 11) dly_start = 1'b0;
            if (i == 10) dly_start = 1'b1;
            if (i == 20) bus_read = 1'b0;
            if (i == 28) begin
                chk("FC mid-delay", bus_dout, 8'h01);
                bus_read = 1'b1;
            end
        end
        chk("delay busy cycles", busy_cnt, 72);
        chk("delay first busy", first_busy, 1);
        chk("delay last busy", last_busy, 72);
        chk("FC rd_stb count", stb_cnt, 1);

        // Zero-length delay never asserts busy.
        busy_cnt = 0;
        @(negedge osc);
        dly_usec  = 12'd0;
        dly_start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge osc);
            dly_start = 1'b0;
            if (dly_busy) busy_cnt++;
        end
        chk("zero delay busy", busy_cnt, 0);

        // Saturation on the 8-bit instance: 24*100 = 2400 -> 255.
        busy_cnt = 0;
        @(negedge osc);
        dly_usec8  = 12'd100;
        dly_start8 = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge osc);
            dly_start8 = 1'b0;
            if (dly_busy8) busy_cnt++;
        end
        chk("saturated busy cycles", busy_cnt, 255);

        // Reset mid-operation: dout nonzero, timer running, write edge in flight.
        set_addr(8'hFD);
        do_read(vecs[0], "pre-reset read");
        @(negedge osc);
        dly_usec  = 12'd3;
        dly_start = 1'b1;
        @(negedge osc);
        dly_start = 1'b0;
        bus_din   = 8'h77;
        bus_write = 1'b1;
        stb_cnt   = 0;
        @(negedge osc);
        rst       = 1'b1;
        bus_write = 1'b0;
        @(negedge osc);
        chk("outputs after rst", {bus_dout, bus_oe, wr_stb, wr_addr, wr_data, rd_stb, rd_addr, dly_busy},
            '0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge osc);
            if (wr_stb) stb_cnt++;
        end
        chk("in-flight write dropped", stb_cnt, 0);
        set_addr(8'h33);
        do_write(8'h44, 1'b0, 8'h33, "post-reset write");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
